// File: rtl/uart_tx_fifo_port_pkg.sv
// Shared definitions for the UART transmit port: FSM state encoding,
// default baud divisor and a parity helper.
package uart_tx_fifo_port_pkg;

  // 25 MHz system clock divided down to 115200 baud.
  localparam int UART_CLKS_115200_25MHZ = 217;

  // Transmit FSM states. PARITY is only visited in the parity-enabled build.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Even parity bit: XOR of all data bits.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_port_byte_fifo.sv
// Byte-wide circular FIFO with wrap-around pointers and an occupancy count.
// Pushes while full and pops while empty are ignored; a push and a pop on
// the same edge leave the count unchanged. The head is read combinationally
// so the consumer can load it on the same edge it pops.
module uart_tx_fifo_port_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          push_ok;
  logic          pop_ok;
  logic [7:0]    slot [DEPTH];

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign count   = count_q;
  assign dout    = slot[rd_ptr_q];

  // One storage register per entry, written when the write pointer selects it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [7:0] entry_q;
    // Capture the incoming byte into this entry on an accepted push.
    always_ff @(posedge clk) begin
      if (push_ok && (wr_ptr_q == AW'(gi))) entry_q <= din;
    end
    assign slot[gi] = entry_q;
  end

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers and count; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_port.sv
// Buffered UART transmitter: bytes arrive on a valid/ready port, queue in a
// small FIFO and are sent LSB-first as 8N1 frames on txd.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (8E1, 11 bit periods per frame).
module uart_tx_fifo_port
  import uart_tx_fifo_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_115200_25MHZ,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        wr_valid,
  input  logic [7:0]                  wr_data,
  output logic                        wr_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        txd
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q;
  logic [BW-1:0] baud_q;
  logic [BW-1:0] baud_d;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    shift_d;
  logic          txd_q;
  logic          rdy_q;
  logic          baud_last;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;
`ifdef UART_TX_PARITY_EN
  logic          parity_q;
`endif

  // wr_ready is held low in reset and comes up on the first edge after release.
  assign wr_ready   = rdy_q & ~fifo_full;
  assign fifo_push  = wr_valid & wr_ready;
  assign fifo_pop   = (state_q == IDLE) & ~fifo_empty;
  assign busy       = (state_q != IDLE) || (fifo_count != '0);
  assign txd        = txd_q;
  assign baud_last  = (baud_q == BAUD_LAST);
  assign baud_d     = baud_q + 1'b1;
  assign shift_d    = {1'b0, shift_q[7:1]};

  uart_tx_fifo_port_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .din    (wr_data),
    .pop    (fifo_pop),
    .dout   (fifo_dout),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Write-port enable: low during reset, high from the first edge afterwards.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rdy_q <= 1'b0;
    else         rdy_q <= 1'b1;
  end

  // Transmit FSM with baud counter; txd is registered so the line never glitches.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          if (!fifo_empty) begin
            shift_q   <= fifo_dout;
            baud_q    <= '0;
            bit_idx_q <= '0;
            txd_q     <= 1'b0;
            state_q   <= START;
`ifdef UART_TX_PARITY_EN
            parity_q  <= even_parity(fifo_dout);
`endif
          end
        end
        START: begin
          if (baud_last) begin
            baud_q  <= '0;
            txd_q   <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_d;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              txd_q   <= parity_q;
              state_q <= PARITY;
`else
              txd_q   <= 1'b1;
              state_q <= STOP;
`endif
            end else begin
              shift_q   <= shift_d;
              txd_q     <= shift_d[0];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            baud_q <= baud_d;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_last) begin
            baud_q  <= '0;
            txd_q   <= 1'b1;
            state_q <= STOP;
          end else begin
            baud_q <= baud_d;
          end
        end
`endif
        STOP: begin
          txd_q <= 1'b1;
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_d;
          end
        end
        default: begin
          baud_q  <= '0;
          txd_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_port.sv
// Scoreboard bench for uart_tx_fifo_port (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Accepted bytes are queued as expected frames; a line monitor rebuilds each
// frame from txd and compares it cycle by cycle against the queued byte.
// Define UART_TX_PARITY_EN for both RTL and bench to exercise the parity build.
module tb_uart_tx_fifo_port;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready;
  logic [2:0] fifo_count;
  logic       busy;
  logic       txd;

  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] exp_q[$];

  uart_tx_fifo_port #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .fifo_count (fifo_count),
    .busy       (busy),
    .txd        (txd)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- line monitor / scoreboard ----------------
  bit          mon_active = 1'b0;
  int          mon_cnt = 0;
  int          idle_run = 0;
  bit          pend_at_end = 1'b0;
  logic [43:0] cap;
  logic [43:0] expv;
  logic [7:0]  mb;

  always @(negedge clk) begin
    if (!resetn) begin
      mon_active  = 1'b0;
      idle_run    = 0;
      pend_at_end = 1'b0;
    end else if (!mon_active) begin
      if (txd === 1'b0) begin
        mon_active = 1'b1;
        cap        = '0;
        cap[0]     = txd;
        mon_cnt    = 1;
        if (pend_at_end) chk("interframe_gap", 64'(idle_run), 64'd1);
        pend_at_end = 1'b0;
      end else begin
        idle_run++;
      end
    end else begin
      cap[mon_cnt] = txd;
      mon_cnt++;
      if (mon_cnt == FRAME) begin
        mon_active = 1'b0;
        idle_run   = 0;
        chk("frame_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mb   = exp_q.pop_front();
          expv = '0;
          for (int i = 0; i < FRAME; i++) begin
            int k;
            k = i / CPB;
            if (k == 0)           expv[i] = 1'b0;
            else if (k <= 8)      expv[i] = mb[k-1];
`ifdef UART_TX_PARITY_EN
            else if (k == 9)      expv[i] = ^mb;
`endif
            else                  expv[i] = 1'b1;
          end
          chk($sformatf("frame_%02h", mb), 64'(cap), 64'(expv));
          $display("frame byte=%02h line=%011h", mb, cap);
        end
        pend_at_end = (exp_q.size() != 0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at a negedge; leaves wr_valid high and returns at the negedge after acceptance.
  task automatic write_byte(input logic [7:0] b, output int waited);
    waited   = 0;
    wr_valid = 1'b1;
    wr_data  = b;
    while (wr_ready !== 1'b1 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 500) chk("wr_ready_timeout", 64'(wr_ready), 64'd1);
    @(posedge clk);
    exp_q.push_back(b);
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_active || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(n < 3000), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int w;
    int prev_cnt;
    int lows;

    // Reset values
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", 64'(txd), 64'd1);
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", 64'(wr_ready), 64'd1);
    @(negedge clk);

    // Single byte A5: latency and busy release
    write_byte(8'hA5, w);
    wr_valid = 1'b0;
    chk("a5_txd_idle_after_accept", 64'(txd), 64'd1);
    chk("a5_count_after_accept", 64'(fifo_count), 64'd1);
    chk("a5_busy_after_accept", 64'(busy), 64'd1);
    @(negedge clk);
    chk("a5_start_low", 64'(txd), 64'd0);
    chk("a5_count_after_pop", 64'(fifo_count), 64'd0);
    repeat (FRAME - 1) @(negedge clk);
    chk("a5_busy_last_stop", 64'(busy), 64'd1);
    @(negedge clk);
    chk("a5_busy_after_stop", 64'(busy), 64'd0);
    chk("a5_txd_idle", 64'(txd), 64'd1);
    repeat (2) @(negedge clk);

    // FF into empty FIFO: count 1 for one cycle, busy continuous
    write_byte(8'hFF, w);
    wr_valid = 1'b0;
    chk("ff_count_one", 64'(fifo_count), 64'd1);
    @(negedge clk);
    chk("ff_count_zero", 64'(fifo_count), 64'd0);
    lows = 0;
    for (int i = 0; i < FRAME - 1; i++) begin
      if (busy !== 1'b1) lows++;
      @(negedge clk);
    end
    chk("ff_busy_continuous", 64'(lows), 64'd0);
    @(negedge clk);
    chk("ff_busy_drop", 64'(busy), 64'd0);
    drain("drain_ff");

    // Held wr_valid with 01..06: five accepted back to back, sixth waits
    for (int i = 1; i <= 5; i++) begin
      write_byte(8'(i), w);
      chk($sformatf("burst_no_wait_%0d", i), 64'(w), 64'd0);
    end
    chk("burst_count_full", 64'(fifo_count), 64'd4);
    chk("burst_ready_low_full", 64'(wr_ready), 64'd0);
    write_byte(8'h06, w);
    wr_valid = 1'b0;
    chk("burst_sixth_waited", 64'(w > 0), 64'd1);
    drain("drain_burst");

    // Full FIFO with wr_valid held across the pop edge
    write_byte(8'h11, w);
    write_byte(8'h22, w);
    write_byte(8'h33, w);
    write_byte(8'h44, w);
    write_byte(8'h55, w);
    chk("full_count", 64'(fifo_count), 64'd4);
    chk("full_ready_low", 64'(wr_ready), 64'd0);
    wr_data  = 8'h66;
    prev_cnt = int'(fifo_count);
    w = 0;
    while (wr_ready !== 1'b1 && w < 500) begin
      prev_cnt = int'(fifo_count);
      @(negedge clk);
      w++;
    end
    chk("pop_edge_prev_count", 64'(prev_cnt), 64'd4);
    chk("pop_edge_refused_count", 64'(fifo_count), 64'd3);
    @(posedge clk);
    exp_q.push_back(8'h66);
    @(negedge clk);
    wr_valid = 1'b0;
    chk("after_refill_count", 64'(fifo_count), 64'd4);
    drain("drain_full");

    // Reset during DATA bit 3 of 00, with 5A still queued
    write_byte(8'h00, w);
    write_byte(8'h5A, w);
    wr_valid = 1'b0;
    repeat (17) @(negedge clk);
    chk("abort_line_low_bit3", 64'(txd), 64'd0);
    chk("abort_busy_before", 64'(busy), 64'd1);
    #2 resetn = 1'b0;
    #1;
    chk("abort_txd_async", 64'(txd), 64'd1);
    chk("abort_count", 64'(fifo_count), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(wr_ready), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    chk("abort_no_residual_frame", 64'(lows), 64'd0);
    chk("abort_count_after", 64'(fifo_count), 64'd0);

`ifdef UART_TX_PARITY_EN
    // Parity build: 07 carries parity 1, 03 carries parity 0
    write_byte(8'h07, w);
    wr_valid = 1'b0;
    drain("drain_par07");
    write_byte(8'h03, w);
    wr_valid = 1'b0;
    drain("drain_par03");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_port.md
Name: uart_tx_fifo_port

Overview:
- Serial transmit stage downstream of the RV32I core in the SOC; drives ftdi_txd, which the core currently ties low.
- The core hands it bytes through a valid/ready write port, fed by a memory-mapped store decode.
- The block buffers bytes in a small FIFO and serialises each as 8N1 LSB-first at a fixed bit period.
- Lets the program print without stalling on every bit.

Parameters:
- CLKS_PER_BIT, 217, clk cycles per serial bit (25 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 8, byte entries; power of two, 2..64.

Ports:
- clk  input  1  system clock (the Clockworks-derived clk)
- resetn  input  1  asynchronous active-low reset
- wr_valid  input  1  core presents a byte
- wr_data  input  8  byte to send
- wr_ready  output  1  FIFO can accept a byte this cycle
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the one on the wire
- busy  output  1  a frame is on the wire or the FIFO is non-empty
- txd  output  1  serial line, idle high

Behaviour:
- Reset: one clock; resetn is asynchronous and active-low.
  - Values while resetn=0: txd=1, wr_ready=0, fifo_count=0, busy=0.
  - FIFO pointers cleared, shifter idle, baud counter=0.
  - Reset mid-frame aborts the frame immediately; txd returns high with no clock edge needed.
  - First rising edge after release: wr_ready=1.
- Write handshake:
  - A byte is accepted on a rising edge with wr_valid=1 and wr_ready=1.
  - wr_ready = (fifo_count < FIFO_DEPTH); purely combinational from the count, never from wr_valid.
  - wr_data is sampled only on acceptance.
  - The core may hold wr_valid across cycles; one byte per accepted edge.
- FIFO:
  - Circular buffer with wrap-around pointers; fifo_count updates on the edge after a push or pop.
  - Push and pop on the same edge leave the count unchanged.
  - Full: a write is refused even if a pop occurs the same edge.
  - Empty: no pop. A byte written into an empty FIFO is popped no earlier than the following edge (no write-through).
- Transmit FSM states: IDLE, START, DATA, STOP (plus PARITY when enabled).
  - IDLE: txd=1. If fifo_count>0, pop the head into the shift register, clear the baud counter and bit index, go to START.
    - txd goes low on the edge that enters START, so first-bit latency is 2 edges after write acceptance into an empty FIFO.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: txd=shift[0]. Every CLKS_PER_BIT cycles shift right and increment the bit index. After bit 7 completes, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles, then go to IDLE.
    - Back-to-back bytes: a queued byte is popped on the IDLE cycle after STOP, so there is one extra idle-high cycle between frames.
- Frame length: exactly 10*CLKS_PER_BIT cycles from the START entry edge to the STOP exit edge.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps; width $clog2(CLKS_PER_BIT).
- busy = (state != IDLE) || (fifo_count != 0).
- txd is registered and glitch-free.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - txd = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame is 11*CLKS_PER_BIT cycles.
- Undefined:
  - No PARITY state and no parity logic.
  - Frame is 10*CLKS_PER_BIT cycles (8N1).

Decomposition:
- Shared package/include uart_pkg.v:
  - FSM state localparams: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4 (3-bit encoding).
  - Default baud constant UART_CLKS_115200_25MHZ=217.
- One natural sub-module: byte_fifo.
  - Parameters: depth.
  - Ports: push, din, pop, dout, count, full, empty.
  - Instantiated once.
- The FSM and baud counter stay in the top.

Test Plan (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Write 8'hA5 once after reset → txd low 2 edges later, then the line reads 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total). busy drops the cycle after STOP ends.
- Hold wr_valid with bytes 8'h01..8'h06 while the first frame runs → 5 bytes accepted (1 on the wire + 4 queued); wr_ready=0 while fifo_count=4. Write 6 is accepted only after a pop; all 6 bytes appear serially in order, with a 1-cycle idle gap between frames.
- Fill FIFO to 4, then assert wr_valid on the exact edge the FSM pops → write refused, fifo_count goes 4→3, wr_ready rises next cycle.
- Assert resetn=0 during DATA bit 3 of 8'h00 → txd=1 immediately (asynchronous, no clock edge); fifo_count=0 and busy=0. After release, no residual frame is emitted.
- With UART_TX_PARITY_EN, send 8'h07 → parity bit 1, frame 44 cycles. Send 8'h03 → parity bit 0.
- Write 8'hFF into an empty FIFO and check fifo_count for that byte → reads 1 for exactly one cycle, then 0 once the byte is popped. busy stays 1 continuously until STOP ends.
